// File: rtl/mac_pkg.sv
// Shared constants and helpers for the systolic-array MAC cell.
package mac_pkg;

    localparam int unsigned MAC_N         = 8;
    localparam int unsigned MAC_SUM_WIDTH = 20;

    // Clamp limits for the default partial-sum width.
    localparam longint MAC_SAT_MAX = (longint'(1) <<< (MAC_SUM_WIDTH - 1)) - 1;
    localparam longint MAC_SAT_MIN = -(longint'(1) <<< (MAC_SUM_WIDTH - 1));

    // Sign-extends the low prod_width bits of prod across all 64 bits.
    function automatic logic [63:0] sign_extend_product(input logic [63:0]  prod,
                                                        input int unsigned  prod_width);
        logic signed [63:0] tmp;
        tmp = signed'(prod << (64 - prod_width));
        return tmp >>> (64 - prod_width);
    endfunction

endpackage

// File: rtl/mac_mult.sv
// Combinational n x n signed multiplier with a full-precision 2n-bit product.
module mac_mult #(
    parameter int unsigned n = 8
) (
    input  logic signed [n-1:0]   a,
    input  logic signed [n-1:0]   b,
    output logic signed [2*n-1:0] p
);

    always_comb begin
        p = (2*n)'(a) * (2*n)'(b);
    end

endmodule

// File: rtl/mac_unit.sv
// Signed multiply-accumulate cell: mac_out <= acc_in + xin*win, xout <= xin, one-cycle latency.
// Define MAC_UNIT_SAT_EN to clamp the sum instead of wrapping modulo 2^SUM_WIDTH.
module mac_unit
    import mac_pkg::*;
#(
    parameter int unsigned n         = MAC_N,
    parameter int unsigned SUM_WIDTH = 2 * n + 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [n-1:0]         xin,
    input  logic signed [n-1:0]         win,
    input  logic signed [SUM_WIDTH-1:0] acc_in,
    output logic signed [SUM_WIDTH-1:0] mac_out,
    output logic signed [n-1:0]         xout
);

    if (n < 2 || n > 16) begin : gen_bad_n
        $error("mac_unit: n must be in 2..16");
    end
    if (SUM_WIDTH < 2 * n + 1 || SUM_WIDTH > 63) begin : gen_bad_sum_width
        $error("mac_unit: SUM_WIDTH must be in 2*n+1..63");
    end

    logic signed [2*n-1:0]       prod;
    logic        [63:0]          prod_ext64;
    logic signed [SUM_WIDTH-1:0] prod_ext;
    logic signed [SUM_WIDTH-1:0] sum;
    logic                        unused_prod_ext_hi;

    logic signed [SUM_WIDTH-1:0] mac_q, mac_d;
    logic signed [n-1:0]         x_q;

    mac_mult #(
        .n (n)
    ) u_mult (
        .a (xin),
        .b (win),
        .p (prod)
    );

    always_comb begin
        prod_ext64 = sign_extend_product(64'(prod), 2 * n);
        prod_ext   = signed'(prod_ext64[SUM_WIDTH-1:0]);
    end

    assign unused_prod_ext_hi = ^prod_ext64[63:SUM_WIDTH];

`ifdef MAC_UNIT_SAT_EN
    localparam logic signed [SUM_WIDTH-1:0] SAT_MAX = {1'b0, {(SUM_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_WIDTH-1:0] SAT_MIN = {1'b1, {(SUM_WIDTH-1){1'b0}}};

    logic signed [SUM_WIDTH:0] sum_wide;

    always_comb begin
        sum_wide = (SUM_WIDTH+1)'(acc_in) + (SUM_WIDTH+1)'(prod_ext);
        // Top two bits disagree only when the true sum left the SUM_WIDTH range.
        if (sum_wide[SUM_WIDTH] != sum_wide[SUM_WIDTH-1]) begin
            sum = sum_wide[SUM_WIDTH] ? SAT_MIN : SAT_MAX;
        end else begin
            sum = sum_wide[SUM_WIDTH-1:0];
        end
    end
`else
    always_comb begin
        sum = acc_in + prod_ext;
    end
`endif

    always_comb begin
        mac_d = sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mac_q <= '0;
            x_q   <= '0;
        end else begin
            mac_q <= mac_d;
            x_q   <= xin;
        end
    end

    assign mac_out = mac_q;
    assign xout    = x_q;

endmodule

// File: tb/tb_mac_unit.sv
// Self-checking bench for mac_unit against an integer-arithmetic reference model.
module tb_mac_unit;

    localparam int unsigned N  = 8;
    localparam int unsigned SW = 20;
    localparam longint      SUM_MOD = longint'(1) <<< SW;
    localparam longint      SUM_MAX = (longint'(1) <<< (SW - 1)) - 1;
    localparam longint      SUM_MIN = -(longint'(1) <<< (SW - 1));

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [N-1:0]  xin;
    logic signed [N-1:0]  win;
    logic signed [SW-1:0] acc_in;
    logic signed [SW-1:0] mac_out;
    logic signed [N-1:0]  xout;

    int n_checks = 0;
    int n_fail   = 0;

    mac_unit #(
        .n         (N),
        .SUM_WIDTH (SW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .xin     (xin),
        .win     (win),
        .acc_in  (acc_in),
        .mac_out (mac_out),
        .xout    (xout)
    );

    always #5 clk = ~clk;

    // Mathematical sum, then either clamp or reduce modulo 2^SW into the signed range.
    function automatic longint model_mac(input int x, input int w, input int acc);
        longint s;
        s = longint'(acc) + longint'(x) * longint'(w);
`ifdef MAC_UNIT_SAT_EN
        if (s > SUM_MAX) s = SUM_MAX;
        if (s < SUM_MIN) s = SUM_MIN;
`else
        s = ((s % SUM_MOD) + SUM_MOD) % SUM_MOD;
        if (s > SUM_MAX) s = s - SUM_MOD;
`endif
        return s;
    endfunction

    // Drive one input vector, let one rising edge take it, then settle past the edge.
    task automatic cycle(input int x, input int w, input int acc, input bit r);
        xin    = N'(x);
        win    = N'(w);
        acc_in = SW'(acc);
        rst    = r;
        @(posedge clk);
        #1;
    endtask

    function automatic int rand_op();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    function automatic int rand_acc();
        return int'($urandom_range(0, 32'(SUM_MOD - 1))) - int'(SUM_MOD / 2);
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(5, 5, 7, 1'b1);
            n_checks++;
            if (mac_out !== '0) begin
                n_fail++;
                $display("FAIL reset_mac edge %0d: got %0d want 0", i, mac_out);
            end
            n_checks++;
            if (xout !== '0) begin
                n_fail++;
                $display("FAIL reset_xout edge %0d: got %0d want 0", i, xout);
            end
        end
        cycle(5, 5, 7, 1'b0);
        n_checks++;
        if (mac_out !== SW'(32)) begin
            n_fail++;
            $display("FAIL post_reset_mac: got %0d want 32", mac_out);
        end
        n_checks++;
        if (xout !== N'(5)) begin
            n_fail++;
            $display("FAIL post_reset_xout: got %0d want 5", xout);
        end
    endtask

    task automatic test_basic();
        cycle(3, -4, 100, 1'b0);
        n_checks++;
        if (mac_out !== SW'(88)) begin
            n_fail++;
            $display("FAIL basic_mac: got %0d want 88", mac_out);
        end
        n_checks++;
        if (xout !== N'(3)) begin
            n_fail++;
            $display("FAIL basic_xout: got %0d want 3", xout);
        end
    endtask

    task automatic test_extremes();
        cycle(-128, -128, 0, 1'b0);
        n_checks++;
        if (mac_out !== SW'(16384)) begin
            n_fail++;
            $display("FAIL extreme_neg_neg: got %0d want 16384", mac_out);
        end
        cycle(-128, 127, -1000, 1'b0);
        n_checks++;
        if (mac_out !== SW'(-17256)) begin
            n_fail++;
            $display("FAIL extreme_neg_pos: got %0d want -17256", mac_out);
        end
        n_checks++;
        if (xout !== N'(-128)) begin
            n_fail++;
            $display("FAIL extreme_xout: got %0d want -128", xout);
        end
    endtask

    task automatic test_back_to_back();
        int x, w, acc;
        longint exp_mac;
        for (int i = 0; i < 10; i++) begin
            x = rand_op();
            w = rand_op();
            acc = rand_acc();
            exp_mac = model_mac(x, w, acc);
            cycle(x, w, acc, 1'b0);
            n_checks++;
            if (mac_out !== SW'(exp_mac)) begin
                n_fail++;
                $display("FAIL b2b_mac vec %0d: got %0d want %0d", i, mac_out, exp_mac);
            end
            n_checks++;
            if (xout !== N'(x)) begin
                n_fail++;
                $display("FAIL b2b_xout vec %0d: got %0d want %0d", i, xout, x);
            end
        end
    endtask

    task automatic test_overflow();
        longint exp_pos, exp_neg;
`ifdef MAC_UNIT_SAT_EN
        exp_pos = 524287;
        exp_neg = -524288;
`else
        exp_pos = -524288;
        exp_neg = 524287;
`endif
        cycle(1, 1, 524287, 1'b0);
        n_checks++;
        if (mac_out !== SW'(exp_pos)) begin
            n_fail++;
            $display("FAIL overflow_pos: got %0d want %0d", mac_out, exp_pos);
        end
        cycle(-1, 1, -524288, 1'b0);
        n_checks++;
        if (mac_out !== SW'(exp_neg)) begin
            n_fail++;
            $display("FAIL overflow_neg: got %0d want %0d", mac_out, exp_neg);
        end
    endtask

    task automatic test_mid_reset();
        int x, w, acc;
        longint exp_mac;
        bit r;
        for (int i = 0; i < 6; i++) begin
            x = rand_op();
            w = rand_op();
            acc = rand_acc();
            r = (i == 3);
            exp_mac = r ? 0 : model_mac(x, w, acc);
            cycle(x, w, acc, r);
            n_checks++;
            if (mac_out !== SW'(exp_mac)) begin
                n_fail++;
                $display("FAIL midrst_mac step %0d: got %0d want %0d", i, mac_out, exp_mac);
            end
            n_checks++;
            if (xout !== (r ? N'(0) : N'(x))) begin
                n_fail++;
                $display("FAIL midrst_xout step %0d: got %0d want %0d", i, xout, r ? 0 : x);
            end
        end
    endtask

    task automatic test_random();
        int x, w, acc;
        longint exp_mac;
        for (int i = 0; i < 200; i++) begin
            x = rand_op();
            w = rand_op();
            // Bias some accumulators to the rails to exercise overflow handling.
            case (i % 4)
                0: acc = int'(SUM_MAX) - int'($urandom_range(0, 20000));
                1: acc = int'(SUM_MIN) + int'($urandom_range(0, 20000));
                default: acc = rand_acc();
            endcase
            exp_mac = model_mac(x, w, acc);
            cycle(x, w, acc, 1'b0);
            n_checks++;
            if (mac_out !== SW'(exp_mac)) begin
                n_fail++;
                $display("FAIL random_mac %0d: x=%0d w=%0d acc=%0d got %0d want %0d",
                         i, x, w, acc, mac_out, exp_mac);
            end
            n_checks++;
            if (xout !== N'(x)) begin
                n_fail++;
                $display("FAIL random_xout %0d: got %0d want %0d", i, xout, x);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        xin    = '0;
        win    = '0;
        acc_in = '0;
        #2;
        test_reset();
        test_basic();
        test_extremes();
        test_back_to_back();
        test_overflow();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_unit.md
Name: mac_unit

Overview:
- Signed integer multiply-accumulate cell for the ECG CNN accelerator's systolic array.
- Each cycle it computes acc_in + xin*win and registers the result.
- It forwards xin one cycle later so that activations ripple to the neighbouring cell.
- Default build is INT8 operands with a 20-bit partial-sum chain.

Parameters:
- n, 8: operand width in bits (xin, win, xout), two's complement. Legal range 2..16.
- SUM_WIDTH, 2*n+4 (20 at default): accumulator width for acc_in and mac_out, two's complement. Must be at least 2*n+1; elaboration fails otherwise.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- xin  in  n  signed activation operand.
- win  in  n  signed weight operand.
- acc_in  in  SUM_WIDTH  signed incoming partial sum.
- mac_out  out  SUM_WIDTH  signed registered result.
- xout  out  n  signed registered copy of xin.

Behaviour:
- Single clock domain: clk. Reset rst is synchronous and active-high.
- On a clk rising edge with rst=1: mac_out <= 0, xout <= 0. No other state exists.
- On a clk rising edge with rst=0:
  - mac_out <= acc_in + sext(xin*win).
  - xout <= xin.
- Latency is exactly 1 cycle. Throughput is one operation per cycle. There is no handshake, no enable and no stall; inputs are sampled on every edge.
- Arithmetic:
  - The product is a full-precision signed 2n-bit value, so -128*-128 = +16384 is not truncated.
  - The product is sign-extended to SUM_WIDTH before the addition.
- Default overflow handling: wrap modulo 2^SUM_WIDTH.
- Reset asserted in the middle of a stream clears both outputs on that edge. The first post-reset result appears one edge after rst is deasserted.
- Inputs carrying X/Z propagate X. There is no masking.
- Outputs come directly from flops with no combinational path from input to output.

Optional Feature:
- Macro: MAC_UNIT_SAT_EN.
- Defined: the sum is computed at SUM_WIDTH+1 bits and clamped to [-2^(SUM_WIDTH-1), 2^(SUM_WIDTH-1)-1] before it is registered. At default width that range is [-524288, 524287].
- Not defined: plain wrap-around, as described in Behaviour.
- xout behaviour is identical in both builds.

Decomposition:
- Shared package mac_pkg holds:
  - default constants MAC_N=8 and MAC_SUM_WIDTH=20;
  - the saturation limit constants, derived from SUM_WIDTH;
  - a function sign_extend_product.
- One natural sub-module: mac_mult, a combinational n x n signed multiplier with a 2n-bit output. The add stage, the optional saturation and the output registers stay in mac_unit.

Test Plan:
- Reset: hold rst=1 for 2 edges with xin=5, win=5, acc_in=7 -> mac_out=0 and xout=0. Release rst; the next edge gives mac_out=32 and xout=5.
- Basic signed: xin=3, win=-4, acc_in=100 -> after one edge, mac_out=88 and xout=3.
- Extremes: xin=-128, win=-128, acc_in=0 -> 16384. Then xin=-128, win=127, acc_in=-1000 -> -17256.
- Back-to-back streaming: change inputs on every edge for 10 vectors. Each result must appear exactly one edge later, with no bubbles.
- Overflow: xin=1, win=1, acc_in=524287.
  - Without MAC_UNIT_SAT_EN -> -524288.
  - With MAC_UNIT_SAT_EN -> 524287.
  - Negative case: xin=-1, win=1, acc_in=-524288 -> 524287 (wrap) or -524288 (saturate).
- Mid-stream reset: assert rst for one edge during streaming -> both outputs are 0 on that edge. The stream resumes correctly on the following edge.
